shift_unit: RTL and testbench

Parametrised, multi-cycle shift unit: the successor to the 4-bit single-mode combinational shifter. It supports arbitrary power-of-two width, binary shift amounts, four shift modes and a configurable number of barrel stages per cycle. It has valid/ready handshakes on both sides so it can sit in the execute stage and serve SLL/SRL/SRA (plus rotate) without lengthening the critical path.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_stage.sv | 38 +++
 rtl/shift_unit.sv | 118 +++++++++++
 tb/tb_shift_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the multi-cycle shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: shifts/rotates by 2^k when enabled, otherwise passes data through.
module shift_stage
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  localparam int unsigned SHAMT_W = $clog2(WIDTH),
  localparam int unsigned K_W     = $clog2(SHAMT_W)
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_e        op_i,
  input  logic             sign_i,
  input  logic             en_i,
  input  logic [K_W-1:0]   k_i,
  output logic [WIDTH-1:0] data_o
);

  logic [SHAMT_W:0]   sh;
  logic [SHAMT_W:0]   rsh;
  logic [WIDTH-1:0]   hi_mask;

  always_comb begin
    sh      = (SHAMT_W + 1)'(1) << k_i;
    rsh     = (SHAMT_W + 1)'(WIDTH) - sh;
    // Bits vacated at the top by a right shift of sh.
    hi_mask = ~({WIDTH{1'b1}} >> sh);
    data_o  = data_i;
    if (en_i) begin
      unique case (op_i)
        OP_SLL:  data_o = data_i << sh;
        OP_SRL:  data_o = data_i >> sh;
        OP_SRA:  data_o = (data_i >> sh) | (sign_i ? hi_mask : '0);
        OP_ROL:  data_o = (data_i << sh) | (data_i >> rsh);
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: resolves STAGES_PER_CYCLE barrel stages per cycle behind valid/ready handshakes.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH            = 32,
  parameter  int unsigned STAGES_PER_CYCLE = 1,
  localparam int unsigned SHAMT_W          = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int unsigned N     = ceil_div(SHAMT_W, STAGES_PER_CYCLE);
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned IDX_W = $clog2(N * STAGES_PER_CYCLE + 1);
  localparam int unsigned K_W   = $clog2(SHAMT_W);

  state_e             state_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] shamt_q;
  shift_op_e          op_q;
  logic               sign_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;

  logic [WIDTH-1:0]   chain [STAGES_PER_CYCLE+1];

  assign chain[0]  = data_q;
  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Stage chain for the current cycle; indices past the last shamt bit pass through.
  for (genvar j = 0; j < STAGES_PER_CYCLE; j++) begin : g_stage
    logic [IDX_W-1:0] idx;
    logic             en;
    logic [K_W-1:0]   k;

    always_comb begin
      idx = IDX_W'(cnt_q) * IDX_W'(STAGES_PER_CYCLE) + IDX_W'(j);
      en  = 1'b0;
      k   = '0;
      if (idx < IDX_W'(SHAMT_W)) begin
        k  = K_W'(idx);
        en = shamt_q[k];
      end
    end

    shift_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .data_i (chain[j]),
      .op_i   (op_q),
      .sign_i (sign_q),
      .en_i   (en),
      .k_i    (k),
      .data_o (chain[j+1])
    );
  end

  // Control FSM with registered result; flush wins over all normal traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      shamt_q     <= '0;
      op_q        <= OP_SLL;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            shamt_q <= in_shamt;
            op_q    <= shift_op_e'(in_op);
            sign_q  <= in_data[WIDTH-1];
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          data_q <= chain[STAGES_PER_CYCLE];
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            out_data_q  <= chain[STAGES_PER_CYCLE];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench: a 4-bit/1-stage unit and a 32-bit/2-stage unit against hand-computed results.
module tb_shift_unit;

  logic clk;
  logic rst_n;
  logic flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0]  a_in_data, a_out_data;
  logic [1:0]  a_in_shamt, a_in_op;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_shamt;
  logic [1:0]  b_in_op;

  int total = 0;
  int bad   = 0;

  shift_unit #(.WIDTH(4), .STAGES_PER_CYCLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, check latency/result/handshake.
  task automatic run_op(input bit sel, input logic [31:0] d, input logic [4:0] sh,
                        input logic [1:0] op, input logic [31:0] exp, input string tag);
    int          lat;
    int          n;
    bit          rdy_bad;
    logic        ov;
    logic [31:0] od;
    n = sel ? 3 : 2;
    @(negedge clk);
    if (sel) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_shamt = sh; b_in_op = op;
    end else begin
      a_in_valid = 1'b1; a_in_data = d[3:0]; a_in_shamt = sh[1:0]; a_in_op = op;
    end
    chk({tag, "_rdy"}, 32'(sel ? b_in_ready : a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_in_data  = ~a_in_data;  b_in_data  = ~b_in_data;
    a_in_shamt = ~a_in_shamt; b_in_shamt = ~b_in_shamt;
    a_in_op    = ~a_in_op;    b_in_op    = ~b_in_op;
    lat = 0;
    rdy_bad = 1'b0;
    ov = sel ? b_out_valid : a_out_valid;
    while (!ov && lat < 20) begin
      if (sel ? b_in_ready : a_in_ready) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
      ov = sel ? b_out_valid : a_out_valid;
    end
    if (sel ? b_in_ready : a_in_ready) rdy_bad = 1'b1;
    od = sel ? b_out_data : {28'd0, a_out_data};
    chk({tag, "_lat"}, 32'(lat), 32'(n));
    chk({tag, "_data"}, od, exp);
    chk({tag, "_busyrdy"}, 32'(rdy_bad), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_vdrop"}, 32'(sel ? b_out_valid : a_out_valid), 32'd0);
  endtask

  task automatic wait_a_valid(output int lat);
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_op = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_ov", 32'(a_out_valid), 32'd0);
    chk("rst_a_od", 32'(a_out_data), 32'd0);
    chk("rst_b_ov", 32'(b_out_valid), 32'd0);
    chk("rst_b_od", b_out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_a_rdy", 32'(a_in_ready), 32'd1);
    chk("rst_b_rdy", 32'(b_in_ready), 32'd1);

    // 4-bit unit, one stage per cycle.
    run_op(1'b0, 32'h1, 5'd0, 2'b00, 32'h1, "sll0");
    run_op(1'b0, 32'h1, 5'd1, 2'b00, 32'h2, "sll1");
    run_op(1'b0, 32'h1, 5'd2, 2'b00, 32'h4, "sll2");
    run_op(1'b0, 32'h1, 5'd3, 2'b00, 32'h8, "sll3");
    run_op(1'b0, 32'h8, 5'd2, 2'b10, 32'hE, "sra2");
    run_op(1'b0, 32'h8, 5'd2, 2'b01, 32'h2, "srl2");
    run_op(1'b0, 32'h9, 5'd1, 2'b11, 32'h3, "rol1");
    run_op(1'b0, 32'h9, 5'd0, 2'b11, 32'h9, "rol0");
    run_op(1'b0, 32'h8, 5'd0, 2'b10, 32'h8, "sra0");
    run_op(1'b0, 32'h6, 5'd3, 2'b01, 32'h0, "srl3");

    // 32-bit unit, two stages per cycle.
    run_op(1'b1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, "b_sra31");
    run_op(1'b1, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, "b_sll31");
    run_op(1'b1, 32'h8000_0001, 5'd4,  2'b11, 32'h0000_0018, "b_rol4");
    run_op(1'b1, 32'hF000_0000, 5'd5,  2'b01, 32'h0780_0000, "b_srl5");
    run_op(1'b1, 32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000, "b_sra_pos");
    run_op(1'b1, 32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, "b_rol0");

    // Backpressure: result must hold while the consumer stalls.
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 4'h3; a_in_shamt = 2'd2; a_in_op = 2'b00;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    wait_a_valid(lat);
    chk("bp_lat", 32'(lat), 32'd2);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (a_out_data !== 4'hC || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) seen = 1'b1;
    end
    chk("bp_hold", 32'(seen), 32'd0);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_vdrop", 32'(a_out_valid), 32'd0);
    chk("bp_rdy", 32'(a_in_ready), 32'd1);
    chk("bp_keep", 32'(a_out_data), 32'hC);
    run_op(1'b0, 32'h5, 5'd1, 2'b11, 32'hA, "bp_next");

    // Flush during the second busy cycle discards the request.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 4'h5; a_in_shamt = 2'd1; a_in_op = 2'b00;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_rdy", 32'(a_in_ready), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (a_out_valid) seen = 1'b1;
    end
    chk("fl_novalid", 32'(seen), 32'd0);
    run_op(1'b0, 32'h3, 5'd1, 2'b00, 32'h6, "fl_next");

    // A request held during flush is not accepted.
    @(negedge clk);
    flush = 1'b1;
    a_in_valid = 1'b1; a_in_data = 4'h1; a_in_shamt = 2'd1; a_in_op = 2'b00;
    #1;
    chk("flreq_rdy", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; a_in_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (a_out_valid) seen = 1'b1;
    end
    chk("flreq_novalid", 32'(seen), 32'd0);

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 4'h3; a_in_shamt = 2'd1; a_in_op = 2'b00;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rb_ov", 32'(a_out_valid), 32'd0);
    chk("rb_od", 32'(a_out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rb_rdy", 32'(a_in_ready), 32'd1);

    // Asynchronous reset mid-DONE.
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 4'h9; a_in_shamt = 2'd1; a_in_op = 2'b11;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    wait_a_valid(lat);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", 32'(a_out_data), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_ov", 32'(a_out_valid), 32'd0);
    chk("rd_od", 32'(a_out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    #1;
    chk("rd_rdy", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rd_idle_ov", 32'(a_out_valid), 32'd0);
    run_op(1'b0, 32'hC, 5'd1, 2'b10, 32'hE, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
